fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder. It holds the program counter and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order responses. Returned words go into a small prefetch FIFO that presents instr/instr_pc to the decoder under a valid/ready handshake. A redirect input from branch resolution flushes the FIFO, discards in-flight responses, and restarts fetch at the new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (low 2 bits ignored)
FIFO_DEPTH, 2, prefetch entries; also the cap on (FIFO occupancy + outstanding requests); must be >=1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address (= pc, bits[1:0]=0)
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response word valid (in order, one per accepted request, latency >=1 cycle)
imem_rsp_data  input  32  response instruction word
instr  output  32  FIFO head instruction to decoder; 32'h0000_0013 (ADDI x0,x0,0) when FIFO empty
instr_pc  output  32  PC of FIFO head; 0 when empty
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decoder consumes head this cycle
redirect_valid  input  1  branch/jump redirect
redirect_pc  input  32  redirect target (bits[1:0] forced to 0)
err_rsp  output  1  sticky: response arrived with zero outstanding requests

Behaviour:
- Reset (async assert, sync-effect deassert): pc=RESET_PC&~3, FIFO empty, outstanding=0, state=RUN, err_rsp=0, imem_req_valid=0, instr_valid=0, instr=32'h0000_0013, instr_pc=0.
- FSM states: RUN, FLUSH.
- RUN issue rule: imem_req_valid = (state==RUN) && !redirect_valid && (fifo_count+outstanding < FIFO_DEPTH). imem_req_valid is combinational from registered state plus redirect_valid; request address is registered pc.
- Request accepted (valid&&ready): pc <= pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding++.
- Response in RUN: push {data, pc_of_request} into FIFO, outstanding--. Per-entry PC comes from a tag queue/counter of issued addresses. instr_valid asserts the cycle after the response edge. Minimum latency: request cycle N, response N+1, instr_valid N+2.
- Pop: instr_valid&&instr_ready removes head. Simultaneous push and pop allowed; count unchanged. Push never finds the FIFO full because of the issue cap.
- Redirect (any state): next edge: FIFO cleared, pc <= redirect_pc&~3. A pop in the same cycle still counts as consumed. If outstanding after this cycle's response is >0, go to FLUSH, else RUN. No request is issued in a redirect cycle.
- FLUSH: no requests issued. Each response is dropped, outstanding--. Leave for RUN at the edge where outstanding reaches 0. A redirect during FLUSH updates pc and remains in FLUSH. A response arriving in a redirect cycle is discarded.
- Response with outstanding==0: ignored, err_rsp<=1 until reset.
- Outstanding counter width clog2(FIFO_DEPTH)+1. Neither the counter nor the FIFO pointers may over/underflow.
- instr_ready while empty: no effect.

Test Plan:
- Reset release, memory always ready, 1-cycle response with data=addr+0x100: req addr 0x0,0x4,... in order; first instr_valid 2 cycles after first request; instr=0x100/instr_pc=0 then 0x104/0x4; NOP 0x00000013 shown before that.
- instr_ready held low: exactly FIFO_DEPTH (2) requests issued then imem_req_valid=0; raising instr_ready for 1 cycle allows exactly one new request.
- Redirect to 0x203 with 2 outstanding (4-cycle latency): FIFO empties next cycle, FLUSH drops both responses, first new request addr=0x200, instr_pc=0x200.
- Redirect in the same cycle as an instr handshake and a response: the popped instr is counted once, the response is dropped, instr_valid=0 next cycle.
- RESET_PC=32'hFFFF_FFF8: request sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Spurious imem_rsp_valid with nothing outstanding: err_rsp=1 and stays set, FIFO unchanged. Assert rst_n mid-FLUSH: all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//
// Holds the program counter, issues word-aligned fetch requests, and buffers
// the returned words in a small prefetch FIFO. A redirect flushes the FIFO,
// restarts fetch at the new PC and drops any responses still in flight.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   imem_req_valid     fetch request valid
//   imem_req_addr      fetch address (registered pc, bits[1:0] = 0)
//   imem_req_ready     memory accepts the request this cycle
//   imem_rsp_valid     response word valid (in order, one per accepted request)
//   imem_rsp_data      response instruction word
//   instr, instr_pc    FIFO head word and its PC (NOP / 0 when empty)
//   instr_valid        FIFO non-empty
//   instr_ready        decoder consumes the head this cycle
//   redirect_valid     branch/jump redirect
//   redirect_pc        redirect target (bits[1:0] forced to 0)
//   err_rsp            sticky: a response arrived with nothing outstanding
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never waits on ready. imem_req_valid may drop without a
// transfer only because of a redirect (the fetch stream is abandoned).
// instr_valid/instr stay stable until consumed or flushed by a redirect.

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        err_rsp
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0]      NOP      = 32'h0000_0013;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   CAP      = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      fifo_data [FIFO_DEPTH];
  logic [31:0]      fifo_pc   [FIFO_DEPTH];

  logic             req_fire;
  logic             rsp_known;
  logic             rsp_spurious;
  logic             push;
  logic             pop;
  logic [31:0]      rsp_pc;
  logic [CNT_W:0]   in_use;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO entries plus in-flight requests never exceed FIFO_DEPTH, so every
  // response accepted in RUN is guaranteed a free FIFO slot.
  assign in_use = {1'b0, fifo_count} + {1'b0, outstanding};

  // Gated with rst_n so the request line is low while reset is held.
  assign imem_req_valid = rst_n && (state == RUN) && !redirect_valid && (in_use < CAP);
  assign imem_req_addr  = pc;

  assign req_fire     = imem_req_valid && imem_req_ready;
  assign rsp_known    = imem_rsp_valid && (outstanding != '0);
  assign rsp_spurious = imem_rsp_valid && (outstanding == '0);
  assign push         = rsp_known && (state == RUN) && !redirect_valid;
  assign pop          = instr_valid && instr_ready;

  // In RUN every outstanding request was issued since the last redirect, so
  // they are consecutive words ending at pc-4; the oldest is pc-4*outstanding.
  assign rsp_pc = pc - 32'({outstanding, 2'b00});

  assign outstanding_nxt = outstanding + CNT_W'(req_fire) - CNT_W'(rsp_known);

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = (outstanding_nxt != '0) ? FLUSH : RUN;
    end else if ((state == FLUSH) && (outstanding_nxt == '0)) begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC & ~32'h3;
      outstanding <= '0;
      err_rsp     <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      if (rsp_spurious) begin
        err_rsp <= 1'b1;
      end
      if (redirect_valid) begin
        pc <= redirect_pc & ~32'h3;
      end else if (req_fire) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // FIFO control. A redirect clears it; a same-cycle pop is simply absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

  assign instr_valid = (fifo_count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : NOP;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr] : 32'h0;

endmodule
